// File: rtl/seg_quad_pkg.sv
// Shared definitions for the segment quadrant classifier.
//   - quadrant index constants (q0 UL, q1 UR, q2 LL, q3 LR)
//   - FSM state type
//   - quadrant weights used by the optional weighted score
//   - nearest_thr(): decides whether a count is strictly nearer thr_a than thr_b
package seg_quad_pkg;

    localparam int Q_UL     = 0;
    localparam int Q_UR     = 1;
    localparam int Q_LL     = 2;
    localparam int Q_LR     = 3;
    localparam int NUM_QUAD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } seg_state_e;

    localparam logic [3:0] W_UL = 4'd3;
    localparam logic [3:0] W_UR = 4'd1;
    localparam logic [3:0] W_LL = 4'd5;
    localparam logic [3:0] W_LR = 4'd1;

    function automatic logic [3:0] quad_weight(input int q);
        case (q)
            Q_UL:    return W_UL;
            Q_UR:    return W_UR;
            Q_LL:    return W_LL;
            default: return W_LR;
        endcase
    endfunction

    // Operands are zero-extended to 32 bits by the caller (counter width must
    // not exceed 32). Distances are formed one bit wider than the operands so
    // the unsigned absolute difference can never wrap. A tie returns 0.
    function automatic logic nearest_thr(input logic [31:0] cnt,
                                         input logic [31:0] thr_a,
                                         input logic [31:0] thr_b);
        logic [32:0] dist_a;
        logic [32:0] dist_b;
        dist_a = (cnt >= thr_a) ? {1'b0, cnt - thr_a} : {1'b0, thr_a - cnt};
        dist_b = (cnt >= thr_b) ? {1'b0, cnt - thr_b} : {1'b0, thr_b - cnt};
        return (dist_a < dist_b);
    endfunction

endpackage

// File: rtl/seg_quad_window_dec.sv
// Raster position decoder for the character windows.
// Maps (hcnt, vcnt) to the window it falls in, if any.
// Ports:
//   hcnt, vcnt  in   current column / row
//   in_window   out  position lies inside one of the NUM_SEG windows
//   seg_idx     out  window index (valid when in_window)
//   quad        out  quadrant {bottom, right}: 0 UL, 1 UR, 2 LL, 3 LR
module seg_quad_window_dec #(
    parameter int NUM_SEG   = 6,
    parameter int SEG_IW    = 3,
    parameter int SEG_X0    = 51,
    parameter int SEG_PITCH = 90,
    parameter int SEG_W     = 74,
    parameter int ROW_Y0    = 151,
    parameter int QUAD_H    = 75
) (
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
    output logic              in_window,
    output logic [SEG_IW-1:0] seg_idx,
    output logic [1:0]        quad
);

    logic [31:0] hx;
    logic [31:0] vy;
    logic        row_in;

    assign hx     = {22'd0, hcnt};
    assign vy     = {22'd0, vcnt};
    assign row_in = (vy >= ROW_Y0) && (vy < ROW_Y0 + 2 * QUAD_H);

    always_comb begin
        in_window = 1'b0;
        seg_idx   = '0;
        quad      = 2'd0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (row_in && (hx >= SEG_X0 + s * SEG_PITCH) &&
                (hx < SEG_X0 + s * SEG_PITCH + SEG_W)) begin
                in_window = 1'b1;
                seg_idx   = SEG_IW'(s);
                quad[0]   = (hx >= SEG_X0 + s * SEG_PITCH + SEG_W / 2);
                quad[1]   = (vy >= ROW_Y0 + QUAD_H);
            end
        end
    end

endmodule

// File: rtl/seg_quad_classifier.sv
// Per-frame digit-segment classifier on the VGA pixel path.
// Counts key-colour pixels in each quadrant of NUM_SEG character windows,
// then classifies every quadrant as nearer thr_a (1) or not (0).
// Optional feature macro: SEG_QUAD_WEIGHT_EN enables the weighted seg_score;
// without it seg_score is constant 0.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   hcnt, vcnt    raster position of pixel_in
//   pixel_in      current pixel (key nibble is the top 4 bits)
//   thr_a, thr_b  per-quadrant reference counts, entry [s*4+q]
//   pixel_out     pixel_in inside any window, else 0 (1-cycle latency)
//   seg_code      per segment {q3,q2,q1,q0}, 1 = nearer thr_a
//   seg_score     weighted score per segment (0 unless weighting enabled)
//   result_valid  1-cycle pulse when seg_code/seg_score update
//   busy          high in ACCUM or EVAL
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for frame start (hcnt==0 && vcnt==0)
// ACCUM | counting key pixels per quadrant; frame start restarts
// EVAL  | classifying one segment per cycle into the staging registers
// DONE  | committing staged results and pulsing result_valid
module seg_quad_classifier
    import seg_quad_pkg::*;
#(
    parameter int         NUM_SEG    = 6,
    parameter int         PIX_W      = 12,
    parameter logic [3:0] KEY_NIBBLE = 4'hA,
    parameter int         CNT_W      = 14,
    parameter int         SEG_X0     = 51,
    parameter int         SEG_PITCH  = 90,
    parameter int         SEG_W      = 74,
    parameter int         ROW_Y0     = 151,
    parameter int         QUAD_H     = 75
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   hcnt,
    input  logic [9:0]                   vcnt,
    input  logic [PIX_W-1:0]             pixel_in,
    input  logic [NUM_SEG*4*CNT_W-1:0]   thr_a,
    input  logic [NUM_SEG*4*CNT_W-1:0]   thr_b,
    output logic [PIX_W-1:0]             pixel_out,
    output logic [NUM_SEG*4-1:0]         seg_code,
    output logic [NUM_SEG*4-1:0]         seg_score,
    output logic                         result_valid,
    output logic                         busy
);

    localparam int                SEG_IW   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int                NCNT     = NUM_SEG * NUM_QUAD;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [9:0]        EVAL_ROW = 10'(ROW_Y0 + 2 * QUAD_H);
    localparam logic [SEG_IW-1:0] LAST_IDX = SEG_IW'(NUM_SEG - 1);

    seg_state_e state_q, state_d;

    logic              frame_start;
    logic              frame_end;
    logic              in_window;
    logic [SEG_IW-1:0] seg_idx;
    logic [1:0]        quad;
    logic              key_hit;

    logic              cnt_clr;
    logic              cnt_en;
    logic              eval_en;
    logic              commit;

    logic [CNT_W-1:0]     cnt_q [NCNT];
    logic [SEG_IW-1:0]    eval_idx_q;
    logic [3:0]           eval_code;
    logic [NUM_SEG*4-1:0] code_stage_q;

    assign frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
    assign frame_end   = (hcnt == 10'd0) && (vcnt == EVAL_ROW);
    assign key_hit     = (pixel_in[PIX_W-1 -: 4] == KEY_NIBBLE);
    assign busy        = (state_q == ACCUM) || (state_q == EVAL);

    seg_quad_window_dec #(
        .NUM_SEG   (NUM_SEG),
        .SEG_IW    (SEG_IW),
        .SEG_X0    (SEG_X0),
        .SEG_PITCH (SEG_PITCH),
        .SEG_W     (SEG_W),
        .ROW_Y0    (ROW_Y0),
        .QUAD_H    (QUAD_H)
    ) u_window_dec (
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .in_window (in_window),
        .seg_idx   (seg_idx),
        .quad      (quad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame start always wins: from any busy or finishing state it clears
    // the counters and restarts accumulation, dropping any pending result.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        eval_en = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    cnt_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (frame_end) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    cnt_clr = 1'b1;
                end else begin
                    eval_en = 1'b1;
                    if (eval_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    cnt_clr = 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_en && in_window && key_hit) begin
            for (int i = 0; i < NCNT; i++) begin
                if ((i == int'(seg_idx) * NUM_QUAD + int'(quad)) && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !eval_en) begin
            eval_idx_q <= '0;
        end else begin
            eval_idx_q <= eval_idx_q + SEG_IW'(1);
        end
    end

    // Segment select by constant-index loop keeps every array and bus access
    // in range even for eval_idx values that never occur.
    always_comb begin
        eval_code = 4'd0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (eval_idx_q == SEG_IW'(s)) begin
                for (int q = 0; q < NUM_QUAD; q++) begin
                    eval_code[q] = nearest_thr(32'(cnt_q[s*NUM_QUAD+q]),
                                               32'(thr_a[(s*NUM_QUAD+q)*CNT_W +: CNT_W]),
                                               32'(thr_b[(s*NUM_QUAD+q)*CNT_W +: CNT_W]));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_stage_q <= '0;
        end else if (eval_en) begin
            for (int s = 0; s < NUM_SEG; s++) begin
                if (eval_idx_q == SEG_IW'(s)) begin
                    code_stage_q[s*4 +: 4] <= eval_code;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_code     <= '0;
            result_valid <= 1'b0;
            pixel_out    <= '0;
        end else begin
            result_valid <= commit;
            if (commit) begin
                seg_code <= code_stage_q;
            end
            pixel_out <= in_window ? pixel_in : '0;
        end
    end

`ifdef SEG_QUAD_WEIGHT_EN
    logic [3:0]           eval_score;
    logic [NUM_SEG*4-1:0] score_stage_q;

    always_comb begin
        eval_score = 4'd0;
        for (int q = 0; q < NUM_QUAD; q++) begin
            eval_score = eval_score + (eval_code[q] ? quad_weight(q) : 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_stage_q <= '0;
            seg_score     <= '0;
        end else begin
            if (eval_en) begin
                for (int s = 0; s < NUM_SEG; s++) begin
                    if (eval_idx_q == SEG_IW'(s)) begin
                        score_stage_q[s*4 +: 4] <= eval_score;
                    end
                end
            end
            if (commit) begin
                seg_score <= score_stage_q;
            end
        end
    end
`else
    assign seg_score = '0;
`endif

endmodule

// File: tb/tb_seg_quad_classifier.sv
// Self-checking bench for seg_quad_classifier: a 14-bit-counter instance and
// an 8-bit-counter instance share the raster stimulus. A bench-side model
// counts key pixels per quadrant; expected codes are queued when a frame is
// closed and compared when result_valid fires.
module tb_seg_quad_classifier;

    localparam int          NS   = 6;
    localparam logic [11:0] KEY  = 12'hA5C;

    logic               clk = 1'b0;
    logic               rst;
    logic [9:0]         hcnt;
    logic [9:0]         vcnt;
    logic [11:0]        pixel_in;
    logic [NS*4*14-1:0] thr_a;
    logic [NS*4*14-1:0] thr_b;
    logic [NS*4*8-1:0]  thr_a8;
    logic [NS*4*8-1:0]  thr_b8;
    logic [11:0]        pixel_out, pixel_out8;
    logic [NS*4-1:0]    seg_code, seg_score, seg_code8, seg_score8;
    logic               result_valid, busy, result_valid8, busy8;

    int ta14 [24];
    int tb14 [24];
    int ta8  [24];
    int tb8  [24];
    int m14  [24];
    int m8   [24];
    bit model_accum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] prev_code;
    logic [23:0] q_code14  [$];
    logic [23:0] q_score14 [$];
    logic [23:0] q_code8   [$];

    always #5 clk = ~clk;

    seg_quad_classifier u_dut (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .pixel_in(pixel_in),
        .thr_a(thr_a), .thr_b(thr_b), .pixel_out(pixel_out), .seg_code(seg_code),
        .seg_score(seg_score), .result_valid(result_valid), .busy(busy)
    );

    seg_quad_classifier #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .pixel_in(pixel_in),
        .thr_a(thr_a8), .thr_b(thr_b8), .pixel_out(pixel_out8), .seg_code(seg_code8),
        .seg_score(seg_score8), .result_valid(result_valid8), .busy(busy8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Independent window model: returns s*4+q, or -1 outside every window.
    function automatic int model_slot(input int h, input int v);
        int s, x;
        if (v < 151 || v > 300 || h < 51) return -1;
        s = (h - 51) / 90;
        x = (h - 51) % 90;
        if (s > 5 || x >= 74) return -1;
        return s * 4 + ((x >= 37) ? 1 : 0) + ((v >= 226) ? 2 : 0);
    endfunction

    function automatic int weight(input int q);
        case (q)
            0: return 3;
            1: return 1;
            2: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 24; i++) begin
            m14[i] = 0;
            m8[i]  = 0;
        end
    endtask

    task automatic clear_thr();
        for (int i = 0; i < 24; i++) begin
            ta14[i] = 0; tb14[i] = 0; ta8[i] = 0; tb8[i] = 0;
        end
    endtask

    task automatic apply_thr();
        for (int i = 0; i < 24; i++) begin
            thr_a[i*14 +: 14] = 14'(ta14[i]);
            thr_b[i*14 +: 14] = 14'(tb14[i]);
            thr_a8[i*8 +: 8]  = 8'(ta8[i]);
            thr_b8[i*8 +: 8]  = 8'(tb8[i]);
        end
    endtask

    // Drive one pixel for one clock, mirror the expected counting in the
    // model, and return 1 time unit after the edge.
    task automatic drive(input int h, input int v, input logic [11:0] p);
        int slot;
        hcnt = 10'(h);
        vcnt = 10'(v);
        pixel_in = p;
        if (h == 0 && v == 0) begin
            clear_model();
            model_accum = 1'b1;
        end else if (model_accum) begin
            slot = model_slot(h, v);
            if (p[11:8] == 4'hA && slot >= 0) begin
                if (m14[slot] < 16383) m14[slot]++;
                if (m8[slot] < 255) m8[slot]++;
            end
            if (h == 0 && v == 301) model_accum = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        logic [23:0] c14, s14, c8;
        c14 = '0; s14 = '0; c8 = '0;
        for (int s = 0; s < NS; s++) begin
            for (int q = 0; q < 4; q++) begin
                if (absd(m14[s*4+q], ta14[s*4+q]) < absd(m14[s*4+q], tb14[s*4+q])) begin
                    c14[s*4+q] = 1'b1;
`ifdef SEG_QUAD_WEIGHT_EN
                    s14[s*4 +: 4] = s14[s*4 +: 4] + 4'(weight(q));
`endif
                end
                if (absd(m8[s*4+q], ta8[s*4+q]) < absd(m8[s*4+q], tb8[s*4+q]))
                    c8[s*4+q] = 1'b1;
            end
        end
        q_code14.push_back(c14);
        q_score14.push_back(s14);
        q_code8.push_back(c8);
        prev_code = c14;
    endtask

    task automatic close_frame(input string tag);
        int lat;
        bit got;
        logic [23:0] e14, es, e8;
        apply_thr();
        push_expected();
        drive(0, 301, 12'h000);
        check_val({tag, "_busy_eval"}, 32'(busy), 1);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            drive(700, 400, KEY);
            if (result_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        check_val({tag, "_latency"}, lat, 7);
        e14 = q_code14.pop_front();
        es  = q_score14.pop_front();
        e8  = q_code8.pop_front();
        if (got) begin
            check_val({tag, "_code"}, seg_code, e14);
            check_val({tag, "_score"}, seg_score, es);
            check_val({tag, "_valid8"}, 32'(result_valid8), 1);
            check_val({tag, "_code8"}, seg_code8, e8);
            check_val({tag, "_busy_idle"}, 32'(busy), 0);
        end
    endtask

    task automatic abort_frame();
        bit seen;
        drive(0, 301, 12'h000);
        for (int k = 0; k < 3; k++) drive(700, 400, 12'h000);
        drive(0, 0, 12'h000);
        check_val("abort_busy", 32'(busy), 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(700, 400, 12'h000);
            seen = seen | result_valid | result_valid8;
        end
        check_val("abort_no_pulse", 32'(seen), 0);
        check_val("abort_hold_code", seg_code, prev_code);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pix"}, pixel_out, 0);
        check_val({tag, "_code"}, seg_code, 0);
        check_val({tag, "_score"}, seg_score, 0);
        check_val({tag, "_valid"}, 32'(result_valid), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_busy8"}, 32'(busy8), 0);
    endtask

    int pt_h [9] = '{60, 130, 124, 125, 51, 50, 574, 575, 60};
    int pt_v [9] = '{160, 160, 160, 160, 151, 151, 300, 300, 301};
    bit pt_in[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 0};

    initial begin
        rst = 1'b1;
        model_accum = 1'b0;
        prev_code = '0;
        clear_model();
        clear_thr();
        apply_thr();
        drive(60, 160, KEY);
        drive(60, 160, KEY);
        check_reset_outputs("reset");
        rst = 1'b0;
        drive(700, 400, 12'h000);
        check_val("idle_busy", 32'(busy), 0);

        // Frame A: full seg0 q0, tie / near cases, last-column pixels, noise.
        drive(0, 0, 12'h000);
        check_val("frameA_busy_accum", 32'(busy), 1);
        for (int v = 151; v < 226; v++)
            for (int h = 51; h < 88; h++) drive(h, v, KEY);
        for (int i = 0; i < 50; i++) drive(178 + i % 37, 151 + i / 37, KEY);
        for (int i = 0; i < 50; i++) drive(231 + i % 37, 226 + i / 37, KEY);
        for (int v = 281; v <= 300; v++) drive(574, v, KEY);
        for (int i = 0; i < 10; i++) drive(411 + i, 160, 12'h9FF);
        for (int h = 125; h <= 140; h++) drive(h, 200, KEY);
        drive(60, 150, KEY);
        drive(50, 160, KEY);
        drive(60, 301, KEY);
        clear_thr();
        ta14[0]  = 2800; tb14[0]  = 0;
        ta14[5]  = 0;    tb14[5]  = 100;
        ta14[10] = 60;   tb14[10] = 100;
        ta14[16] = 0;    tb14[16] = 7;
        ta14[23] = 20;   tb14[23] = 0;
        ta8[0]   = 255;  tb8[0]   = 254;
        close_frame("frameA");

        // Frame B: pixel pass-through boundaries, then reset mid-ACCUM.
        drive(0, 0, 12'h000);
        for (int i = 0; i < 9; i++) begin
            drive(pt_h[i], pt_v[i], KEY);
            check_val($sformatf("pix_%0d_%0d", pt_h[i], pt_v[i]), pixel_out,
                      pt_in[i] ? 32'(KEY) : 32'd0);
        end
        rst = 1'b1;
        model_accum = 1'b0;
        drive(60, 160, KEY);
        check_reset_outputs("midreset");
        rst = 1'b0;
        clear_model();
        prev_code = '0;

        // Frame C: normal frame after reset.
        drive(0, 0, 12'h000);
        for (int h = 358; h < 368; h++) drive(h, 151, KEY);
        clear_thr();
        ta14[13] = 10; tb14[13] = 3;
        ta8[13]  = 10; tb8[13]  = 9;
        close_frame("frameC");

        // Frame D: frame start during EVAL aborts; counters must restart.
        drive(0, 0, 12'h000);
        for (int h = 411; h < 441; h++) drive(h, 226, KEY);
        clear_thr();
        ta14[18] = 30; tb14[18] = 0;
        ta8[18]  = 30; tb8[18]  = 0;
        apply_thr();
        abort_frame();
        close_frame("frameD");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
